// File: rtl/eth_idma_meta_arb.sv
// Round-robin arbiter for iDMA meta words from several Ethernet DMA sources.
// Each source has its own FIFO, and per-source credits cap granted-but-uncompleted transfers.
module eth_idma_meta_arb #(
    parameter int NumChan     = 2,
    parameter int MetaWidth   = 128,
    parameter int FifoDepth   = 4,
    parameter int MaxInflight = 8,
    parameter int ChanW       = (NumChan > 1) ? $clog2(NumChan) : 1,
    parameter int CntW        = $clog2(MaxInflight + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumChan-1:0][MetaWidth-1:0]   meta_i,
    input  logic [NumChan-1:0]                  mode_i,
    input  logic [NumChan-1:0]                  valid_i,
    output logic [NumChan-1:0]                  ready_o,
    output logic [MetaWidth-1:0]                meta_o,
    output logic                                mode_o,
    output logic [ChanW-1:0]                    chan_o,
    output logic                                valid_o,
    input  logic                                ready_i,
    input  logic                                done_valid_i,
    input  logic [ChanW-1:0]                    done_chan_i,
    output logic [NumChan-1:0][CntW-1:0]        inflight_o,
    output logic                                err_o
);

    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int OccW = $clog2(FifoDepth + 1);
    localparam int EntW = MetaWidth + 1;

    logic [EntW-1:0]              mem_r      [NumChan][FifoDepth];
    logic [PtrW-1:0]              rd_ptr_r   [NumChan];
    logic [PtrW-1:0]              wr_ptr_r   [NumChan];
    logic [OccW-1:0]              occ_r      [NumChan];
    logic [OccW-1:0]              occ_next_s [NumChan];
    logic [EntW-1:0]              head_s     [NumChan];
    logic [NumChan-1:0]           ready_r;
    logic [NumChan-1:0]           push_s;
    logic [NumChan-1:0]           pop_s;
    logic [NumChan-1:0]           elig_s;

    logic [MetaWidth-1:0]         meta_r;
    logic                         mode_r;
    logic [ChanW-1:0]             chan_r;
    logic                         valid_r;
    logic [ChanW-1:0]             rr_ptr_r;
    logic [ChanW-1:0]             rr_next_s;
    logic [ChanW-1:0]             grant_s;
    logic                         grant_found_s;
    logic [EntW-1:0]              sel_s;
    logic                         load_s;
    logic                         hs_s;

    logic [NumChan-1:0][CntW-1:0] inflight_r;
    logic [NumChan-1:0][CntW-1:0] infl_next_s;
    logic                         illegal_s;
    logic                         err_r;

    // ready_o reflects registered occupancy only, so a pop never unblocks it combinationally
    assign push_s  = valid_i & ready_r;
    assign hs_s    = valid_r & ready_i;
    assign load_s  = (!valid_r || ready_i) && grant_found_s;

    assign ready_o    = ready_r;
    assign meta_o     = meta_r;
    assign mode_o     = mode_r;
    assign chan_o     = chan_r;
    assign valid_o    = valid_r;
    assign inflight_o = inflight_r;
    assign err_o      = err_r;

    // FIFO storage write port; data needs no reset because occupancy guards every read
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NumChan; c++) begin
            if (push_s[c]) begin
                mem_r[c][wr_ptr_r[c]] <= {mode_i[c], meta_i[c]};
            end
        end
    end

    // FIFO heads, pop decode and next occupancy
    always_comb begin
        for (int c = 0; c < NumChan; c++) begin
            head_s[c] = mem_r[c][rd_ptr_r[c]];
            pop_s[c]  = load_s && (grant_s == ChanW'(c));
            case ({push_s[c], pop_s[c]})
                2'b10:   occ_next_s[c] = occ_r[c] + OccW'(1'b1);
                2'b01:   occ_next_s[c] = occ_r[c] - OccW'(1'b1);
                default: occ_next_s[c] = occ_r[c];
            endcase
        end
    end

    // FIFO pointers, occupancy and registered ready
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NumChan; c++) begin
                rd_ptr_r[c] <= {PtrW{1'b0}};
                wr_ptr_r[c] <= {PtrW{1'b0}};
                occ_r[c]    <= {OccW{1'b0}};
            end
            ready_r <= {NumChan{1'b1}};
        end else begin
            for (int c = 0; c < NumChan; c++) begin
                if (push_s[c]) begin
                    wr_ptr_r[c] <= wr_ptr_r[c] + PtrW'(1'b1);
                end
                if (pop_s[c]) begin
                    rd_ptr_r[c] <= rd_ptr_r[c] + PtrW'(1'b1);
                end
                occ_r[c]   <= occ_next_s[c];
                ready_r[c] <= (occ_next_s[c] != OccW'(FifoDepth));
            end
        end
    end

    // Eligibility counts the word parked in the output register against its source's limit
    always_comb begin
        for (int c = 0; c < NumChan; c++) begin
            elig_s[c] = (occ_r[c] != {OccW{1'b0}}) &&
                        (({1'b0, inflight_r[c]} +
                          (CntW+1)'(valid_r && (chan_r == ChanW'(c)))) < (CntW+1)'(MaxInflight));
        end
    end

    // Round-robin pick: smallest wrapped distance from rr_ptr among eligible sources
    always_comb begin
        int best_v;
        int off_v;
        int rr_v;
        grant_found_s = 1'b0;
        grant_s       = {ChanW{1'b0}};
        best_v        = NumChan;
        off_v         = 0;
        rr_v          = int'(rr_ptr_r);
        for (int c = 0; c < NumChan; c++) begin
            if (c >= rr_v) begin
                off_v = c - rr_v;
            end else begin
                off_v = c + NumChan - rr_v;
            end
            if (elig_s[c] && (off_v < best_v)) begin
                best_v        = off_v;
                grant_s       = ChanW'(c);
                grant_found_s = 1'b1;
            end else begin
                best_v = best_v;
            end
        end
        if (int'(grant_s) == NumChan - 1) begin
            rr_next_s = {ChanW{1'b0}};
        end else begin
            rr_next_s = grant_s + ChanW'(1'b1);
        end
        sel_s = head_s[grant_s];
    end

    // Output stage and round-robin pointer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_r   <= {MetaWidth{1'b0}};
            mode_r   <= 1'b0;
            chan_r   <= {ChanW{1'b0}};
            valid_r  <= 1'b0;
            rr_ptr_r <= {ChanW{1'b0}};
        end else if (load_s) begin
            meta_r   <= sel_s[MetaWidth-1:0];
            mode_r   <= sel_s[MetaWidth];
            chan_r   <= grant_s;
            valid_r  <= 1'b1;
            rr_ptr_r <= rr_next_s;
        end else if (hs_s) begin
            valid_r  <= 1'b0;
        end
    end

    // Credit update; a completion on an idle or nonexistent source only flags an error
    always_comb begin
        logic inc_v;
        logic dec_v;
        inc_v     = 1'b0;
        dec_v     = 1'b0;
        illegal_s = done_valid_i && (int'(done_chan_i) >= NumChan);
        for (int c = 0; c < NumChan; c++) begin
            inc_v          = hs_s && (chan_r == ChanW'(c));
            dec_v          = done_valid_i && (done_chan_i == ChanW'(c));
            infl_next_s[c] = inflight_r[c];
            if (inc_v && !dec_v) begin
                infl_next_s[c] = inflight_r[c] + CntW'(1'b1);
            end else if (dec_v && !inc_v) begin
                if (inflight_r[c] == {CntW{1'b0}}) begin
                    illegal_s = 1'b1;
                end else begin
                    infl_next_s[c] = inflight_r[c] - CntW'(1'b1);
                end
            end else begin
                infl_next_s[c] = inflight_r[c];
            end
        end
    end

    // In-flight counters and sticky error flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_r <= {(NumChan*CntW){1'b0}};
            err_r      <= 1'b0;
        end else begin
            inflight_r <= infl_next_s;
            err_r      <= err_r | illegal_s;
        end
    end

endmodule

// File: tb/tb_eth_idma_meta_arb.sv
// Bench for eth_idma_meta_arb: directed scenarios plus random traffic, all
// checked cycle by cycle against a queue-based model of the arbitration rules.
module tb_eth_idma_meta_arb;

    localparam int NC = 2;
    localparam int MW = 32;
    localparam int FD = 4;
    localparam int MI = 2;
    localparam int CW = $clog2(MI + 1);

    logic                     clk_i = 1'b0;
    logic                     rst_ni;
    logic [NC-1:0][MW-1:0]    meta_i;
    logic [NC-1:0]            mode_i;
    logic [NC-1:0]            valid_i;
    logic [NC-1:0]            ready_o;
    logic [MW-1:0]            meta_o;
    logic                     mode_o;
    logic [0:0]               chan_o;
    logic                     valid_o;
    logic                     ready_i;
    logic                     done_valid_i;
    logic [0:0]               done_chan_i;
    logic [NC-1:0][CW-1:0]    inflight_o;
    logic                     err_o;

    typedef struct packed {
        logic          m;
        logic [MW-1:0] d;
    } ent_t;

    ent_t          mq [NC][$];
    bit            m_valid;
    logic [MW-1:0] m_meta;
    logic          m_mode;
    int            m_chan;
    int            m_rr;
    int            m_infl [NC];
    bit            m_err;

    int n_checks = 0;
    int n_pass   = 0;
    int obs_hs   = 0;
    int obs_hs0  = 0;
    int owed [$];
    int hs_chans [$];
    int b0;

    eth_idma_meta_arb #(
        .NumChan(NC), .MetaWidth(MW), .FifoDepth(FD), .MaxInflight(MI)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .meta_i(meta_i), .mode_i(mode_i),
        .valid_i(valid_i), .ready_o(ready_o), .meta_o(meta_o), .mode_o(mode_o),
        .chan_o(chan_o), .valid_o(valid_o), .ready_i(ready_i),
        .done_valid_i(done_valid_i), .done_chan_i(done_chan_i),
        .inflight_o(inflight_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            mq[c].delete();
            m_infl[c] = 0;
        end
        m_valid = 0; m_meta = '0; m_mode = 1'b0; m_chan = 0; m_rr = 0; m_err = 0;
        owed.delete();
    endtask

    // One clock of the reference behaviour, from the current state and the driven inputs
    task automatic model_step(input logic [NC-1:0] v, input logic [NC-1:0][MW-1:0] d,
                              input logic [NC-1:0] md, input logic rdy,
                              input logic dv, input int dch);
        bit   hs, found, load, i_c, d_c;
        int   g, pend, sz [NC];
        ent_t e;
        hs = m_valid && rdy;
        for (int c = 0; c < NC; c++) sz[c] = mq[c].size();
        found = 0; g = 0;
        for (int k = 0; k < NC; k++) begin
            int c = (m_rr + k) % NC;
            pend = (m_valid && m_chan == c) ? 1 : 0;
            if (!found && sz[c] > 0 && m_infl[c] + pend < MI) begin
                found = 1; g = c;
            end
        end
        load = (!m_valid || rdy) && found;
        if (dv && dch >= NC) m_err = 1;
        for (int c = 0; c < NC; c++) begin
            i_c = hs && (m_chan == c);
            d_c = dv && (dch == c);
            if (i_c && !d_c) m_infl[c]++;
            else if (d_c && !i_c) begin
                if (m_infl[c] == 0) m_err = 1;
                else m_infl[c]--;
            end
        end
        if (load) begin
            e = mq[g].pop_front();
            m_meta = e.d; m_mode = e.m; m_chan = g; m_valid = 1; m_rr = (g + 1) % NC;
        end else if (hs) begin
            m_valid = 0;
        end
        for (int c = 0; c < NC; c++) begin
            if (v[c] && sz[c] < FD) mq[c].push_back({md[c], d[c]});
        end
    endtask

    task automatic compare_model();
        logic [NC-1:0] er;
        for (int c = 0; c < NC; c++) er[c] = (mq[c].size() < FD);
        check("ready", ready_o, er);
        check("valid", valid_o, m_valid);
        if (m_valid) begin
            check("meta", meta_o, m_meta);
            check("mode", mode_o, m_mode);
            check("chan", chan_o, m_chan);
        end
        for (int c = 0; c < NC; c++) check("inflight", inflight_o[c], m_infl[c]);
        check("err", err_o, m_err);
    endtask

    function automatic logic [NC-1:0][MW-1:0] rnd_meta();
        logic [NC-1:0][MW-1:0] r;
        for (int c = 0; c < NC; c++) r[c] = $urandom;
        return r;
    endfunction

    // Called at a falling edge: drive, advance the model, clock once, compare
    task automatic step(input logic [NC-1:0] v, input logic [NC-1:0][MW-1:0] d,
                        input logic [NC-1:0] md, input logic rdy,
                        input logic dv, input logic [0:0] dch);
        valid_i = v; meta_i = d; mode_i = md; ready_i = rdy;
        done_valid_i = dv; done_chan_i = dch;
        if (valid_o && rdy) begin
            owed.push_back(int'(chan_o));
            hs_chans.push_back(int'(chan_o));
            obs_hs++;
            if (chan_o == 1'b0) obs_hs0++;
        end
        model_step(v, d, md, rdy, dv, int'(dch));
        @(posedge clk_i);
        @(negedge clk_i);
        compare_model();
    endtask

    // Random data; completions are taken from the owed list with probability pd percent
    task automatic go_owed(input logic [NC-1:0] v, input logic rdy, input int pd);
        logic       dv;
        logic [0:0] dch;
        dv = 1'b0; dch = 1'b0;
        if (owed.size() > 0 && $urandom_range(0, 99) < pd) begin
            dv = 1'b1; dch = 1'(owed.pop_front());
        end
        step(v, rnd_meta(), NC'($urandom), rdy, dv, dch);
    endtask

    task automatic drive_idle();
        valid_i = '0; meta_i = '0; mode_i = '0; ready_i = 1'b0;
        done_valid_i = 1'b0; done_chan_i = 1'b0;
    endtask

    task automatic apply_reset();
        drive_idle();
        rst_ni = 1'b0;
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        compare_model();
    endtask

    initial begin
        logic [NC-1:0][MW-1:0] d;
        drive_idle();
        rst_ni = 1'b0;
        model_reset();
        #12;
        check("rst_ready", ready_o, 2'b11);
        check("rst_valid", valid_o, 1'b0);
        check("rst_inflight", inflight_o, '0);
        check("rst_err", err_o, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        compare_model();

        // first word latency: accepted at one edge, visible after the next
        d = rnd_meta(); d[0] = 32'h0000_00A5;
        step(2'b01, d, 2'b01, 1'b0, 1'b0, 1'b0);
        check("lat_e0_valid", valid_o, 1'b0);
        step(2'b00, rnd_meta(), 2'b00, 1'b0, 1'b0, 1'b0);
        check("lat_valid", valid_o, 1'b1);
        check("lat_meta", meta_o, 32'h0000_00A5);
        check("lat_mode", mode_o, 1'b1);
        check("lat_chan", chan_o, 1'b0);
        go_owed(2'b00, 1'b1, 0);
        go_owed(2'b00, 1'b0, 100);

        // round robin with both sources kept full and completions returned promptly
        hs_chans.delete();
        for (int i = 0; i < 4; i++) go_owed(2'b11, 1'b0, 0);
        for (int i = 0; i < 12; i++) go_owed(2'b11, 1'b1, 100);
        check("rr_count", hs_chans.size() >= 8, 1'b1);
        if (hs_chans.size() >= 8) begin
            for (int i = 1; i < 8; i++) check("rr_alt", hs_chans[i], hs_chans[i-1] ^ 1);
        end
        for (int i = 0; i < 30; i++) go_owed(2'b00, 1'b1, 100);

        // backpressure: everything fills and stalls, then exactly the held words drain
        for (int i = 0; i < 10; i++) go_owed(2'b11, 1'b0, 100);
        check("bp_ready", ready_o, 2'b00);
        check("bp_valid", valid_o, 1'b1);
        b0 = obs_hs;
        for (int i = 0; i < 30; i++) go_owed(2'b00, 1'b1, 100);
        check("bp_words", obs_hs - b0, 2 * FD + 1);

        // credit limit on ch0 without completions
        apply_reset();
        b0 = obs_hs0;
        for (int i = 0; i < 5; i++) go_owed(2'b01, 1'b1, 0);
        for (int i = 0; i < 8; i++) go_owed(2'b00, 1'b1, 0);
        check("cr_grants", obs_hs0 - b0, 2);
        check("cr_valid", valid_o, 1'b0);
        check("cr_infl0", inflight_o[0], 2);
        go_owed(2'b00, 1'b1, 100);
        for (int i = 0; i < 5; i++) go_owed(2'b00, 1'b1, 0);
        check("cr_grants2", obs_hs0 - b0, 3);
        check("cr_infl0b", inflight_o[0], 2);

        // handshake and completion on ch1 in the same cycle
        step(2'b10, rnd_meta(), 2'b00, 1'b0, 1'b0, 1'b0);
        step(2'b00, rnd_meta(), 2'b00, 1'b0, 1'b0, 1'b0);
        check("sim_pre_chan", chan_o, 1'b1);
        step(2'b00, rnd_meta(), 2'b00, 1'b1, 1'b1, 1'b1);
        check("sim_infl1", inflight_o[1], 0);
        check("sim_err", err_o, 1'b0);

        // completion on an idle source
        step(2'b00, rnd_meta(), 2'b00, 1'b1, 1'b1, 1'b1);
        check("ill_err", err_o, 1'b1);
        check("ill_infl0", inflight_o[0], 2);
        check("ill_infl1", inflight_o[1], 0);
        for (int i = 0; i < 3; i++) step(2'b00, rnd_meta(), 2'b00, 1'b1, 1'b0, 1'b0);
        check("ill_sticky", err_o, 1'b1);

        // asynchronous reset in the middle of traffic
        owed.delete();
        for (int i = 0; i < 4; i++) go_owed(2'b11, 1'b1, 0);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_ready", ready_o, 2'b11);
        check("arst_valid", valid_o, 1'b0);
        check("arst_meta", meta_o, 32'h0);
        check("arst_mode", mode_o, 1'b0);
        check("arst_chan", chan_o, 1'b0);
        check("arst_inflight", inflight_o, '0);
        check("arst_err", err_o, 1'b0);
        drive_idle();
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        compare_model();

        // random traffic with legal completions
        for (int i = 0; i < 600; i++) begin
            go_owed(NC'($urandom), ($urandom_range(0, 3) != 0), 40);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
